encoder_eight_three_queued: RTL and testbench
=============================================

// Module: encoder_eight_three_queued
// PURPOSE
//  Sequential 8-to-3 encoder, the return path for the 3-to-8 decoder. Eight request lines
//  are captured into sticky pending bits. Pending requests drain one per handshake as 3-bit
//  codes on a valid/ready output. Sits between event sources and any consumer of binary
//  indices, e.g. a decoder that drives the per-line acknowledge.
// PARAMETERS
//  N       8   number of request lines (fixed at 8 for this revision)
//  W       3   code width, clog2(N)
//  RR      0   0 = fixed priority (lowest index wins); 1 = round-robin from last grant + 1
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  en           in   1   capture enable for req; when 0, new requests are ignored
//  req          in   N   request lines, level-sampled each cycle
//  out_code     out  W   encoded index of the presented request
//  out_valid    out  1   out_code holds a request
//  out_ready    in   1   consumer accepts out_code when out_valid && out_ready
//  pending      out  N   registered sticky request vector (excludes the presented code)
//  dropped      out  1   one-cycle pulse: a captured req hit an already-pending bit
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_code=0, pending=0, dropped=0,
//   rr_ptr=N-1, state=IDLE. Reset mid-operation discards all pending and presented codes.
//  Capture: set = en ? req : 0. Next pending = (pending & ~load_onehot) | set.
//   If set and clear hit the same bit, set wins; this counts as a new request.
//  dropped <= |(set & pending & ~load_onehot), registered.
//  Pick (combinational, on registered pending only):
//   RR=0: lowest set index.
//   RR=1: first set index scanning rr_ptr+1, rr_ptr+2 ... modulo N (wraps 7 -> 0).
//   found = |pending.
//  FSM, two states:
//   IDLE:    out_valid=0. If found: load picked code into out_code, set out_valid,
//            clear that bit (load_onehot), rr_ptr <= code, go to PRESENT.
//   PRESENT: out_valid=1. out_code is held stable until the handshake.
//            On handshake with found: load the next pick in the same cycle, stay in
//            PRESENT (back-to-back, 1 code per cycle).
//            On handshake without found: out_valid <= 0, go to IDLE.
//            Without a handshake: no load; pending keeps accumulating.
//  Latency: req high at edge t -> pending bit at t+1 -> out_valid/out_code at t+2, if idle.
//  A request for the index currently held in out_code (not yet accepted) re-pends and is
//   presented again later; it does not assert dropped.
//  out_valid never deasserts without a handshake. out_ready is ignored while out_valid=0.
//  en=0 only blocks capture; pending requests still drain.
//  All pending bits set: N codes emitted over N consecutive handshakes, then IDLE.
// STRUCTURE
//  Package enc_pkg: localparams N=8, W=3; typedef enum {IDLE, PRESENT} enc_state_t;
//   function onehot(code) returning the N-bit mask.
//  Sub-module prio_pick: combinational rotating-priority picker.
//   Inputs: vec[N], start[W]. Outputs: code[W], found.
//   RR=0 ties start to 0.
//  Top: pending register, out_code/out_valid register, rr_ptr register, FSM, dropped flop.
// TESTING
//  1 Single req=8'b0000_0100 pulse, en=1, out_ready=1:
//    pending=04 at t+1; out_valid=1, out_code=2 at t+2; IDLE at t+3.
//  2 req=8'hFF one cycle, out_ready=1, RR=0: codes 0,1,2..7 on 8 consecutive cycles,
//    then out_valid=0. With RR=1 and rr_ptr=4: codes 5,6,7,0,1,2,3,4.
//  3 Backpressure: req=8'h81, out_ready=0 for 5 cycles: out_code=0 held stable and
//    pending=80; raise out_ready: next code 7, then idle.
//  4 req bit 3 re-asserted while pending[3]=1: dropped pulses 1 cycle, code 3 emitted
//    once. Same req on the load cycle: no dropped, code 3 emitted twice.
//  5 en=0 with req=8'hFF: pending stays 0, out_valid stays 0.
//    en=1 for one cycle: all 8 captured.
//  6 rst_n low mid-burst (3 of 8 drained): same cycle out_valid=0, pending=0;
//    after release no stale codes appear.

Source files
------------

// File: rtl/encoder_eight_three_queued_pkg.sv
// Shared constants, FSM state type and the index-to-mask helper
// for the queued 8-to-3 encoder.
package enc_pkg;

  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] code);
    onehot = {{(N-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/encoder_eight_three_queued_prio_pick.sv
// Rotating-priority picker: first set bit of vec_i scanning upward from
// start_i with wrap-around; RR=0 pins the scan origin to bit 0.
module encoder_eight_three_queued_prio_pick
  import enc_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] code_o,
  output logic         found_o
);

  logic [W-1:0] start_eff_s;
  logic [W-1:0] idx_s;
  logic [W-1:0] code_s;

  assign start_eff_s = (RR != 0) ? start_i : {W{1'b0}};

  // Scan from the far end back toward the origin so the nearest hit wins.
  always_comb begin
    code_s = {W{1'b0}};
    idx_s  = {W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx_s  = start_eff_s + W'(k);
      code_s = vec_i[idx_s] ? idx_s : code_s;
    end
  end

  assign code_o  = code_s;
  assign found_o = |vec_i;

endmodule

// File: rtl/encoder_eight_three_queued.sv
// Queued 8-to-3 encoder: sticky pending capture, one code presented per
// valid/ready handshake, optional round-robin fairness.
module encoder_eight_three_queued
  import enc_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         dropped
);

  enc_state_t   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_code_q, out_code_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic         dropped_q, dropped_d;

  logic [W-1:0] start_s;
  logic [W-1:0] pick_code_s;
  logic         found_s;
  logic         handshake_s;
  logic         load_s;
  logic [N-1:0] load_onehot_s;
  logic [N-1:0] set_s;

  assign start_s     = rr_ptr_q + {{(W-1){1'b0}}, 1'b1};
  assign handshake_s = out_valid_q & out_ready;

  encoder_eight_three_queued_prio_pick #(
    .RR(RR)
  ) u_pick (
    .vec_i  (pending_q),
    .start_i(start_s),
    .code_o (pick_code_s),
    .found_o(found_s)
  );

  // Presentation FSM: decides when the picked code moves into out_code.
  always_comb begin
    state_d     = state_q;
    out_code_d  = out_code_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          load_s  = 1'b1;
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (handshake_s && found_s) begin
          load_s = 1'b1;
        end else if (handshake_s) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    if (load_s) begin
      out_valid_d = 1'b1;
      out_code_d  = pick_code_s;
      rr_ptr_d    = pick_code_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // A fresh request on the bit being loaded wins over the clear and is not a drop.
  always_comb begin
    load_onehot_s = load_s ? onehot(pick_code_s) : {N{1'b0}};
    set_s         = en ? req : {N{1'b0}};
    pending_d     = (pending_q & ~load_onehot_s) | set_s;
    dropped_d     = |(set_s & pending_q & ~load_onehot_s);
  end

  // State, queue and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= {N{1'b0}};
      out_code_q  <= {W{1'b0}};
      out_valid_q <= 1'b0;
      rr_ptr_q    <= W'(N - 1);
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      dropped_q   <= dropped_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_encoder_eight_three_queued.sv
// Bench for the queued 8-to-3 encoder: fixed-priority and round-robin
// instances driven in parallel and compared against a queue model.
module tb_encoder_eight_three_queued;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       out_ready;
  logic [7:0] req;

  logic [2:0] code0, code1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;
  logic       drop0, drop1;

  int checks = 0;
  int passes = 0;

  logic [7:0] m_pend[2];
  logic       m_valid[2];
  logic [2:0] m_code[2];
  logic [2:0] m_ptr[2];
  logic       m_drop[2];

  always #5 clk = ~clk;

  encoder_eight_three_queued #(.RR(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .out_code(code0), .out_valid(valid0), .out_ready(out_ready),
    .pending(pend0), .dropped(drop0)
  );

  encoder_eight_three_queued #(.RR(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .out_code(code1), .out_valid(valid1), .out_ready(out_ready),
    .pending(pend1), .dropped(drop1)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 8'h00;
      m_valid[d] = 1'b0;
      m_code[d]  = 3'd0;
      m_ptr[d]   = 3'd7;
      m_drop[d]  = 1'b0;
    end
  endtask

  // Queue semantics: index 0 is fixed priority, index 1 is round-robin from last grant + 1.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] setv;
      logic       found, hs, ld, drop, hit;
      int         p;
      setv  = en ? req : 8'h00;
      found = (m_pend[d] != 8'h00);
      hs    = m_valid[d] && out_ready;
      ld    = found && (!m_valid[d] || hs);
      p     = 0;
      hit   = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (d == 0) ? k : (int'(m_ptr[d]) + 1 + k) % 8;
        if (!hit && m_pend[d][i]) begin
          p   = i;
          hit = 1'b1;
        end
      end
      drop = 1'b0;
      for (int i = 0; i < 8; i++)
        if (setv[i] && m_pend[d][i] && !(ld && i == p)) drop = 1'b1;
      if (ld) m_pend[d][p] = 1'b0;
      m_pend[d] = m_pend[d] | setv;
      m_drop[d] = drop;
      if (ld) begin
        m_valid[d] = 1'b1;
        m_code[d]  = p[2:0];
        m_ptr[d]   = p[2:0];
      end else if (hs) begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0; en = 1'b0; req = 8'h00; out_ready = 1'b0;
    #12;
    checks++;
    if ({valid0, code0, pend0, drop0} !== 13'd0)
      $display("FAIL reset_rr0 got v=%0b c=%0d p=%h d=%0b want all zero", valid0, code0, pend0, drop0);
    else passes++;
    checks++;
    if ({valid1, code1, pend1, drop1} !== 13'd0)
      $display("FAIL reset_rr1 got v=%0b c=%0d p=%h d=%0b want all zero", valid1, code1, pend1, drop1);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    en = 1'b1; out_ready = 1'b1; req = 8'h04;
    tick();
    checks++;
    if (pend0 !== 8'h04 || valid0 !== 1'b0)
      $display("FAIL single_capture got p=%h v=%0b want p=04 v=0", pend0, valid0);
    else passes++;
    req = 8'h00;
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd2 || pend0 !== 8'h00)
      $display("FAIL single_present got v=%0b c=%0d p=%h want v=1 c=2 p=00", valid0, code0, pend0);
    else passes++;
    checks++;
    if (valid1 !== 1'b1 || code1 !== 3'd2)
      $display("FAIL single_present_rr got v=%0b c=%0d want v=1 c=2", valid1, code1);
    else passes++;
    tick();
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0)
      $display("FAIL single_idle got v0=%0b v1=%0b want 0 0", valid0, valid1);
    else passes++;
  endtask

  task automatic test_burst();
    req = 8'h10;
    tick();
    req = 8'h00;
    tick();
    tick();
    req = 8'hFF;
    tick();
    checks++;
    if (pend0 !== 8'hFF)
      $display("FAIL burst_capture got p=%h want FF", pend0);
    else passes++;
    req = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (valid0 !== 1'b1 || code0 !== 3'(k))
        $display("FAIL burst_fixed[%0d] got v=%0b c=%0d want v=1 c=%0d", k, valid0, code0, k);
      else passes++;
      checks++;
      if (valid1 !== 1'b1 || code1 !== 3'((5 + k) % 8))
        $display("FAIL burst_rr[%0d] got v=%0b c=%0d want v=1 c=%0d", k, valid1, code1, (5 + k) % 8);
      else passes++;
    end
    tick();
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0)
      $display("FAIL burst_idle got v0=%0b v1=%0b want 0 0", valid0, valid1);
    else passes++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; req = 8'h81;
    tick();
    req = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (valid0 !== 1'b1 || code0 !== 3'd0 || pend0 !== 8'h80)
        $display("FAIL bp_hold[%0d] got v=%0b c=%0d p=%h want v=1 c=0 p=80", k, valid0, code0, pend0);
      else passes++;
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd7 || pend0 !== 8'h00)
      $display("FAIL bp_next got v=%0b c=%0d p=%h want v=1 c=7 p=00", valid0, code0, pend0);
    else passes++;
    tick();
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0)
      $display("FAIL bp_idle got v0=%0b v1=%0b want 0 0", valid0, valid1);
    else passes++;
  endtask

  task automatic test_dropped();
    out_ready = 1'b0; req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    req = 8'h08;
    tick();
    checks++;
    if (pend0 !== 8'h08 || drop0 !== 1'b0)
      $display("FAIL drop_first got p=%h d=%0b want p=08 d=0", pend0, drop0);
    else passes++;
    tick();
    checks++;
    if (drop0 !== 1'b1 || drop1 !== 1'b1 || pend0 !== 8'h08)
      $display("FAIL drop_pulse got d0=%0b d1=%0b p=%h want 1 1 08", drop0, drop1, pend0);
    else passes++;
    req = 8'h00;
    tick();
    checks++;
    if (drop0 !== 1'b0)
      $display("FAIL drop_one_cycle got d=%0b want 0", drop0);
    else passes++;
    out_ready = 1'b1;
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd3 || pend0 !== 8'h00)
      $display("FAIL drop_emit got v=%0b c=%0d p=%h want v=1 c=3 p=00", valid0, code0, pend0);
    else passes++;
    tick();
    checks++;
    if (valid0 !== 1'b0)
      $display("FAIL drop_once got v=%0b want 0", valid0);
    else passes++;
    req = 8'h08;
    tick();
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd3 || pend0 !== 8'h08 || drop0 !== 1'b0)
      $display("FAIL reload_cycle got v=%0b c=%0d p=%h d=%0b want v=1 c=3 p=08 d=0",
               valid0, code0, pend0, drop0);
    else passes++;
    req = 8'h00;
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd3 || pend0 !== 8'h00)
      $display("FAIL reload_twice got v=%0b c=%0d p=%h want v=1 c=3 p=00", valid0, code0, pend0);
    else passes++;
    tick();
    checks++;
    if (valid0 !== 1'b0)
      $display("FAIL reload_idle got v=%0b want 0", valid0);
    else passes++;
  endtask

  task automatic test_enable();
    en = 1'b0; req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pend0 !== 8'h00 || valid0 !== 1'b0 || pend1 !== 8'h00)
        $display("FAIL en_block[%0d] got p0=%h v0=%0b p1=%h want 00 0 00", k, pend0, valid0, pend1);
      else passes++;
    end
    en = 1'b1;
    tick();
    checks++;
    if (pend0 !== 8'hFF)
      $display("FAIL en_capture got p=%h want FF", pend0);
    else passes++;
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (valid0 !== 1'b1 || code0 !== 3'(k))
        $display("FAIL en_drain[%0d] got v=%0b c=%0d want v=1 c=%0d", k, valid0, code0, k);
      else passes++;
    end
    tick();
    checks++;
    if (valid0 !== 1'b0 || pend0 !== 8'h00)
      $display("FAIL en_idle got v=%0b p=%h want 0 00", valid0, pend0);
    else passes++;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; out_ready = 1'b1; req = 8'hFF;
    tick();
    req = 8'h00;
    repeat (4) tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd3)
      $display("FAIL mid_before got v=%0b c=%0d want v=1 c=3", valid0, code0);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid0, pend0, drop0} !== 10'd0 || {valid1, pend1, drop1} !== 10'd0)
      $display("FAIL mid_async got v0=%0b p0=%h v1=%0b p1=%h want 0 00 0 00", valid0, pend0, valid1, pend1);
    else passes++;
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (valid0 !== 1'b0 || valid1 !== 1'b0 || pend0 !== 8'h00)
        $display("FAIL mid_stale[%0d] got v0=%0b v1=%0b p=%h want 0 0 00", k, valid0, valid1, pend0);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom_range(7, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      req       = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
      tick();
      checks++;
      if ({valid0, code0, pend0, drop0} !== {m_valid[0], m_code[0], m_pend[0], m_drop[0]})
        $display("FAIL rand_fixed[%0d] got v=%0b c=%0d p=%h d=%0b want v=%0b c=%0d p=%h d=%0b", c,
                 valid0, code0, pend0, drop0, m_valid[0], m_code[0], m_pend[0], m_drop[0]);
      else passes++;
      checks++;
      if ({valid1, code1, pend1, drop1} !== {m_valid[1], m_code[1], m_pend[1], m_drop[1]})
        $display("FAIL rand_rr[%0d] got v=%0b c=%0d p=%h d=%0b want v=%0b c=%0d p=%h d=%0b", c,
                 valid1, code1, pend1, drop1, m_valid[1], m_code[1], m_pend[1], m_drop[1]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_dropped();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
